// File: rtl/ring_pkg.sv
// Shared definitions for the ring router output arbiter: packet field offsets,
// FSM state and grant encodings.
package ring_pkg;

  localparam int PKT_W     = 49;
  localparam int VALID_BIT = 48;
  localparam int TS_HI     = 47;
  localparam int TS_LO     = 32;
  localparam int SRC_HI    = 31;
  localparam int SRC_LO    = 16;
  localparam int DST_HI    = 15;
  localparam int DST_LO    = 0;

  typedef enum logic {ST_RING_PRI, ST_LOCAL_FORCE} arb_state_t;
  typedef enum logic {GR_RING, GR_LOCAL} grant_t;

endpackage

// File: rtl/ring_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module ring_sat_counter
  import ring_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int MAX   = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_inc,
  input  logic             i_clr,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_count <= '0;
    end else if (i_inc && (r_count != WIDTH'(MAX))) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/ring_output_arbiter.sv
// Per-direction ring output arbiter: through-traffic vs local injection onto one registered link.
// Optional statistics counters are built only when RING_ARB_STATS_EN is defined.
//
// state          | meaning
// ST_RING_PRI    | ring wins ties; blocked-local cycles are counted
// ST_LOCAL_FORCE | local has starved for STARVE_LIMIT cycles and wins the next tie
module ring_output_arbiter
  import ring_pkg::*;
#(
  parameter int PACKET_SIZE  = 49,
  parameter int POLICY       = 1,
  parameter int STARVE_LIMIT = 8,
  parameter int STAT_W       = 32
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_thru_valid,
  input  logic [PACKET_SIZE-1:0] i_thru_pkt,
  output logic                   o_thru_pop,
  input  logic                   i_local_valid,
  input  logic [PACKET_SIZE-1:0] i_local_pkt,
  output logic                   o_local_pop,
  input  logic                   i_bp_stop,
  output logic [PACKET_SIZE-1:0] o_link_out,
  output logic [STAT_W-1:0]      o_stat_ring,
  output logic [STAT_W-1:0]      o_stat_local,
  output logic [STAT_W-1:0]      o_stat_stall
);

  grant_t                 r_last_grant;
  arb_state_t             r_state;
  arb_state_t             w_state_nxt;
  logic [15:0]            w_starve_cnt;
  logic                   w_tie_local;
  logic                   w_grant_ring;
  logic                   w_grant_local;
  logic                   w_starve_inc;
  logic                   w_starve_clr;
  logic [PACKET_SIZE-1:0] r_link;

  always_comb begin
    w_tie_local   = 1'b0;
    w_grant_ring  = 1'b0;
    w_grant_local = 1'b0;
    if (POLICY == 0) begin
      w_tie_local = (r_last_grant == GR_RING);
    end else begin
      w_tie_local = (r_state == ST_LOCAL_FORCE);
    end
    if (!i_bp_stop) begin
      if (i_thru_valid && i_local_valid) begin
        w_grant_local = w_tie_local;
        w_grant_ring  = !w_tie_local;
      end else begin
        w_grant_ring  = i_thru_valid;
        w_grant_local = i_local_valid;
      end
    end
  end

  assign o_thru_pop  = w_grant_ring;
  assign o_local_pop = w_grant_local;

  // Force is entered on the cycle the count reaches the limit so local wins the very next tie.
  always_comb begin
    w_state_nxt  = r_state;
    w_starve_inc = 1'b0;
    w_starve_clr = 1'b0;
    if ((POLICY != 0) && !i_bp_stop) begin
      case (r_state)
        ST_RING_PRI: begin
          if (w_grant_local || !i_local_valid) begin
            w_starve_clr = 1'b1;
          end else begin
            w_starve_inc = 1'b1;
            if (w_starve_cnt >= 16'(STARVE_LIMIT - 1)) begin
              w_state_nxt = ST_LOCAL_FORCE;
            end
          end
        end
        ST_LOCAL_FORCE: begin
          if (w_grant_local || !i_local_valid) begin
            w_starve_clr = 1'b1;
            w_state_nxt  = ST_RING_PRI;
          end
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= ST_RING_PRI;
      r_last_grant <= GR_LOCAL;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant_ring) begin
        r_last_grant <= GR_RING;
      end else if (w_grant_local) begin
        r_last_grant <= GR_LOCAL;
      end
    end
  end

  ring_sat_counter #(
    .WIDTH (16),
    .MAX   (STARVE_LIMIT)
  ) u_starve_cnt (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_inc   (w_starve_inc),
    .i_clr   (w_starve_clr),
    .o_count (w_starve_cnt)
  );

  // The valid bit is forced so a requester with a stale valid field still sends a live packet.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_link <= '0;
    end else if (w_grant_ring) begin
      r_link            <= i_thru_pkt;
      r_link[VALID_BIT] <= 1'b1;
    end else if (w_grant_local) begin
      r_link            <= i_local_pkt;
      r_link[VALID_BIT] <= 1'b1;
    end else begin
      r_link <= '0;
    end
  end

  assign o_link_out = r_link;

`ifdef RING_ARB_STATS_EN
  logic [STAT_W-1:0] r_stat_ring;
  logic [STAT_W-1:0] r_stat_local;
  logic [STAT_W-1:0] r_stat_stall;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_stat_ring  <= '0;
      r_stat_local <= '0;
      r_stat_stall <= '0;
    end else begin
      if (w_grant_ring)  r_stat_ring  <= r_stat_ring + 1'b1;
      if (w_grant_local) r_stat_local <= r_stat_local + 1'b1;
      if ((i_thru_valid || i_local_valid) && i_bp_stop) r_stat_stall <= r_stat_stall + 1'b1;
    end
  end

  assign o_stat_ring  = r_stat_ring;
  assign o_stat_local = r_stat_local;
  assign o_stat_stall = r_stat_stall;
`else
  assign o_stat_ring  = '0;
  assign o_stat_local = '0;
  assign o_stat_stall = '0;
`endif

endmodule

// File: tb/tb_ring_output_arbiter.sv
// Bench for ring_output_arbiter: round-robin and ring-first instances side by side,
// hand-derived vector table, corner sequences and randomized traffic against a reference model.
module tb_ring_output_arbiter;
  import ring_pkg::*;

  localparam int PS  = 49;
  localparam int SW  = 32;
  localparam int LIM = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          thru_valid, local_valid, bp_stop;
  logic [PS-1:0] thru_pkt, local_pkt;
  logic          tp0, lp0, tp1, lp1;
  logic [PS-1:0] link0, link1;
  logic [SW-1:0] sr0, sl0, ss0, sr1, sl1, ss1;

  always #5 clk = ~clk;

  ring_output_arbiter #(.PACKET_SIZE(PS), .POLICY(0), .STARVE_LIMIT(LIM), .STAT_W(SW)) dut0 (
    .i_clk(clk), .i_rst(rst),
    .i_thru_valid(thru_valid), .i_thru_pkt(thru_pkt), .o_thru_pop(tp0),
    .i_local_valid(local_valid), .i_local_pkt(local_pkt), .o_local_pop(lp0),
    .i_bp_stop(bp_stop), .o_link_out(link0),
    .o_stat_ring(sr0), .o_stat_local(sl0), .o_stat_stall(ss0)
  );

  ring_output_arbiter #(.PACKET_SIZE(PS), .POLICY(1), .STARVE_LIMIT(LIM), .STAT_W(SW)) dut1 (
    .i_clk(clk), .i_rst(rst),
    .i_thru_valid(thru_valid), .i_thru_pkt(thru_pkt), .o_thru_pop(tp1),
    .i_local_valid(local_valid), .i_local_pkt(local_pkt), .o_local_pop(lp1),
    .i_bp_stop(bp_stop), .o_link_out(link1),
    .o_stat_ring(sr1), .o_stat_local(sl1), .o_stat_stall(ss1)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: last winner for round-robin, consecutive blocked-local cycles for ring-first.
  bit            m_last_local;
  int            m_blk;
  logic [PS-1:0] m_link0, m_link1;
  int unsigned   m_sr0, m_sl0, m_sr1, m_sl1, m_ss;
  logic          s_tp0, s_lp0, s_tp1, s_lp1;

  typedef struct {
    logic tv, lv, bp;
    logic rp0, lp0, rp1, lp1;
  } vec_t;
  vec_t tbl[23];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [PS-1:0] rnd_pkt();
    return {17'($urandom), 32'($urandom)};
  endfunction

  task automatic model_reset();
    m_last_local = 1'b1;
    m_blk        = 0;
    m_link0      = '0;
    m_link1      = '0;
    m_sr0 = 0; m_sl0 = 0; m_sr1 = 0; m_sl1 = 0; m_ss = 0;
  endtask

  task automatic step(input logic tv, input logic [PS-1:0] tp, input logic lv,
                      input logic [PS-1:0] lp, input logic bp, input logic rs);
    logic          g0r, g0l, g1r, g1l;
    logic [PS-1:0] vmask;
    vmask = '0;
    vmask[PS-1] = 1'b1;
    thru_valid = tv; thru_pkt = tp; local_valid = lv; local_pkt = lp; bp_stop = bp; rst = rs;
    #1;
    s_tp0 = tp0; s_lp0 = lp0; s_tp1 = tp1; s_lp1 = lp1;
    g0r = 1'b0; g0l = 1'b0; g1r = 1'b0; g1l = 1'b0;
    if (!bp) begin
      if (tv && lv) begin
        g0l = !m_last_local;
        g0r = m_last_local;
        g1l = (m_blk >= LIM);
        g1r = !g1l;
      end else begin
        g0r = tv; g0l = lv; g1r = tv; g1l = lv;
      end
    end
    if (!rs) begin
      check("thru_pop0", 64'(tp0), 64'(g0r));
      check("local_pop0", 64'(lp0), 64'(g0l));
      check("thru_pop1", 64'(tp1), 64'(g1r));
      check("local_pop1", 64'(lp1), 64'(g1l));
    end
    @(posedge clk);
    #1;
    if (rs) begin
      model_reset();
    end else begin
      m_link0 = g0r ? (tp | vmask) : (g0l ? (lp | vmask) : '0);
      m_link1 = g1r ? (tp | vmask) : (g1l ? (lp | vmask) : '0);
      if (g0r) m_last_local = 1'b0;
      else if (g0l) m_last_local = 1'b1;
      if (!bp) begin
        if (lv && !g1l) m_blk++;
        else m_blk = 0;
      end
      m_sr0 += 32'(g0r); m_sl0 += 32'(g0l);
      m_sr1 += 32'(g1r); m_sl1 += 32'(g1l);
      if ((tv || lv) && bp) m_ss++;
    end
    check("link_out0", 64'(link0), 64'(m_link0));
    check("link_out1", 64'(link1), 64'(m_link1));
  endtask

  task automatic check_stats();
`ifdef RING_ARB_STATS_EN
    check("stat_ring0", 64'(sr0), 64'(m_sr0));
    check("stat_local0", 64'(sl0), 64'(m_sl0));
    check("stat_stall0", 64'(ss0), 64'(m_ss));
    check("stat_ring1", 64'(sr1), 64'(m_sr1));
    check("stat_local1", 64'(sl1), 64'(m_sl1));
    check("stat_stall1", 64'(ss1), 64'(m_ss));
`else
    check("stat_ring0", 64'(sr0), 64'd0);
    check("stat_local0", 64'(sl0), 64'd0);
    check("stat_stall0", 64'(ss0), 64'd0);
    check("stat_ring1", 64'(sr1), 64'd0);
    check("stat_local1", 64'(sl1), 64'd0);
    check("stat_stall1", 64'(ss1), 64'd0);
`endif
  endtask

  task automatic do_reset();
    step(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
  endtask

  initial begin
    logic [PS-1:0] pkt;
    model_reset();
    thru_valid = 1'b0; local_valid = 1'b0; bp_stop = 1'b0; rst = 1'b1;
    thru_pkt = '0; local_pkt = '0;

    // Table: both valid from reset for 12 cycles, then backpressure freeze and single requesters.
    for (int i = 0; i < 12; i++) begin
      tbl[i] = '{1'b1, 1'b1, 1'b0, (i % 2 == 0), (i % 2 != 0), (i % 4 != 3), (i % 4 == 3)};
    end
    tbl[12] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[13] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[14] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[15] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[16] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[17] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[18] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[19] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[20] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[21] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[22] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

    do_reset();
    check("reset_link0", 64'(link0), 64'd0);
    check("reset_link1", 64'(link1), 64'd0);
    check_stats();

    // Through traffic only, dst=5, stale valid bit clear in the packet.
    for (int i = 0; i < 4; i++) begin
      pkt = '0;
      pkt[DST_HI:DST_LO] = 16'd5;
      pkt[SRC_HI:SRC_LO] = 16'(i + 1);
      step(1'b1, pkt, 1'b0, rnd_pkt(), 1'b0, 1'b0);
      check("t1_thru_pop", 64'(s_tp0 & s_tp1), 64'd1);
      check("t1_link_valid", 64'(link1[VALID_BIT]), 64'd1);
      check("t1_link_dst", 64'(link1[DST_HI:DST_LO]), 64'd5);
    end

    do_reset();
    for (int i = 0; i < 23; i++) begin
      step(tbl[i].tv, rnd_pkt(), tbl[i].lv, rnd_pkt(), tbl[i].bp, 1'b0);
      check($sformatf("tbl%0d_rp0", i), 64'(s_tp0), 64'(tbl[i].rp0));
      check($sformatf("tbl%0d_lp0", i), 64'(s_lp0), 64'(tbl[i].lp0));
      check($sformatf("tbl%0d_rp1", i), 64'(s_tp1), 64'(tbl[i].rp1));
      check($sformatf("tbl%0d_lp1", i), 64'(s_lp1), 64'(tbl[i].lp1));
      if (tbl[i].bp) check($sformatf("tbl%0d_bubble", i), 64'(link1[VALID_BIT]), 64'd0);
      if (i == 11) begin
`ifdef RING_ARB_STATS_EN
        check("t6_stat_ring1", 64'(sr1), 64'd9);
        check("t6_stat_local1", 64'(sl1), 64'd3);
        check("t6_stat_ring0", 64'(sr0), 64'd6);
`else
        check("t6_stat_ring1", 64'(sr1), 64'd0);
        check("t6_stat_local1", 64'(sl1), 64'd0);
        check("t6_stat_ring0", 64'(sr0), 64'd0);
`endif
      end
      if (i == 15) begin
`ifdef RING_ARB_STATS_EN
        check("t4_stat_stall", 64'(ss1), 64'd3);
`else
        check("t4_stat_stall", 64'(ss1), 64'd0);
`endif
      end
    end
    check_stats();

    // Reset mid-stream with ring-first about to force local and round-robin owing local.
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, rnd_pkt(), 1'b1, rnd_pkt(), 1'b0, 1'b0);
    step(1'b1, rnd_pkt(), 1'b1, rnd_pkt(), 1'b0, 1'b1);
    check("t5_link0_cleared", 64'(link0), 64'd0);
    check("t5_link1_cleared", 64'(link1), 64'd0);
    step(1'b1, rnd_pkt(), 1'b1, rnd_pkt(), 1'b0, 1'b0);
    check("t5_tie_ring0", 64'(s_tp0), 64'd1);
    check("t5_tie_ring1", 64'(s_tp1), 64'd1);

    // Randomized traffic with occasional reset.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 9) < 7), rnd_pkt(), ($urandom_range(0, 9) < 7), rnd_pkt(),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 99) == 0));
      if (i % 100 == 99) check_stats();
    end
    check_stats();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
